// File: rtl/main_controller_pkg.sv
// Shared encodings for the multicycle main controller: FSM states, opcodes,
// datapath select codes and the packed control-word bundle.
package main_controller_pkg;

  localparam int unsigned OPCODE_W = 7;
  localparam int unsigned FUNC3_W  = 3;
  localparam int unsigned SEL_W    = 2;

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXEC_R   = 4'd6,
    S_EXEC_I   = 4'd7,
    S_ALUWB    = 4'd8,
    S_BRANCH   = 4'd9,
    S_JAL      = 4'd10,
    S_JALR     = 4'd11,
    S_LUI      = 4'd12,
    S_AUIPC    = 4'd13
  } state_e;

  localparam logic [OPCODE_W-1:0] OP_LOAD   = 7'b0000011;
  localparam logic [OPCODE_W-1:0] OP_STORE  = 7'b0100011;
  localparam logic [OPCODE_W-1:0] OP_RTYPE  = 7'b0110011;
  localparam logic [OPCODE_W-1:0] OP_ITYPE  = 7'b0010011;
  localparam logic [OPCODE_W-1:0] OP_BRANCH = 7'b1100011;
  localparam logic [OPCODE_W-1:0] OP_JAL    = 7'b1101111;
  localparam logic [OPCODE_W-1:0] OP_JALR   = 7'b1100111;
  localparam logic [OPCODE_W-1:0] OP_LUI    = 7'b0110111;
  localparam logic [OPCODE_W-1:0] OP_AUIPC  = 7'b0010111;

  localparam logic [SEL_W-1:0] ALU_ADD  = 2'b00;
  localparam logic [SEL_W-1:0] ALU_SUB  = 2'b01;
  localparam logic [SEL_W-1:0] ALU_FUNC = 2'b10;

  localparam logic [SEL_W-1:0] RES_ALUOUT    = 2'b00;
  localparam logic [SEL_W-1:0] RES_MEMDATA   = 2'b01;
  localparam logic [SEL_W-1:0] RES_ALURESULT = 2'b10;
  localparam logic [SEL_W-1:0] RES_IMM       = 2'b11;

  localparam logic [SEL_W-1:0] SRCA_PC    = 2'b00;
  localparam logic [SEL_W-1:0] SRCA_OLDPC = 2'b01;
  localparam logic [SEL_W-1:0] SRCA_RS1   = 2'b10;

  localparam logic [SEL_W-1:0] SRCB_RS2  = 2'b00;
  localparam logic [SEL_W-1:0] SRCB_IMM  = 2'b01;
  localparam logic [SEL_W-1:0] SRCB_FOUR = 2'b10;

  typedef struct packed {
    logic             pc_write;
    logic             adr_src;
    logic             mem_write;
    logic             ir_write;
    logic [SEL_W-1:0] result_src;
    logic [SEL_W-1:0] alu_src_a;
    logic [SEL_W-1:0] alu_src_b;
    logic [SEL_W-1:0] alu_op;
    logic             reg_write;
    logic             illegal_instr;
  } ctrl_t;

  localparam ctrl_t CTRL_IDLE = '0;

endpackage

// File: rtl/main_controller_branch_unit.sv
// Branch-condition evaluation: func3 selects a flag, func3[0] inverts it.
import main_controller_pkg::*;

module main_controller_branch_unit (
  input  logic [FUNC3_W-1:0] i_func3,
  input  logic               i_zero,
  input  logic               i_lt,
  input  logic               i_ltu,
  output logic               o_taken_c
);

  logic w_cond;

  always_comb begin
    w_cond    = 1'b0;
    o_taken_c = 1'b0;
    case (i_func3[2:1])
      2'b00:   w_cond = i_zero;
      2'b10:   w_cond = i_lt;
      2'b11:   w_cond = i_ltu;
      default: w_cond = 1'b0;
    endcase
    // func3 010/011 have no branch meaning and are never taken
    if (i_func3[2:1] != 2'b01) begin
      o_taken_c = w_cond ^ i_func3[0];
    end
  end

endmodule

// File: rtl/main_controller.sv
// Multicycle RV32 main controller: Moore FSM driving datapath enables and
// selects; only pc_write in BRANCH looks at the ALU flags.
import main_controller_pkg::*;

module main_controller (
  input  logic                clk,
  input  logic                rst,
  input  logic [OPCODE_W-1:0] opcode,
  input  logic [FUNC3_W-1:0]  func3,
  input  logic                zero,
  input  logic                lt,
  input  logic                ltu,
  output logic                pc_write,
  output logic                adr_src,
  output logic                mem_write,
  output logic                ir_write,
  output logic [SEL_W-1:0]    result_src,
  output logic [SEL_W-1:0]    alu_src_a,
  output logic [SEL_W-1:0]    alu_src_b,
  output logic [SEL_W-1:0]    alu_op,
  output logic                reg_write,
  output logic                illegal_instr
);

  state_e r_state;
  state_e w_next_state;
  logic   r_jalr_link;
  logic   w_next_jalr_link;
  logic   w_taken;
  ctrl_t  w_ctrl;

  main_controller_branch_unit u_branch_unit (
    .i_func3   (func3),
    .i_zero    (zero),
    .i_lt      (lt),
    .i_ltu     (ltu),
    .o_taken_c (w_taken)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_FETCH;
      r_jalr_link <= 1'b0;
    end else begin
      r_state     <= w_next_state;
      r_jalr_link <= w_next_jalr_link;
    end
  end

  always_comb begin
    w_next_state     = r_state;
    w_next_jalr_link = 1'b0;
    w_ctrl           = CTRL_IDLE;
    case (r_state)
      S_FETCH: begin
        w_ctrl.ir_write   = 1'b1;
        w_ctrl.pc_write   = 1'b1;
        w_ctrl.alu_src_a  = SRCA_PC;
        w_ctrl.alu_src_b  = SRCB_FOUR;
        w_ctrl.alu_op     = ALU_ADD;
        w_ctrl.result_src = RES_ALURESULT;
        w_next_state      = S_DECODE;
      end
      S_DECODE: begin
        w_ctrl.alu_src_a = SRCA_OLDPC;
        w_ctrl.alu_src_b = SRCB_IMM;
        w_ctrl.alu_op    = ALU_ADD;
        case (opcode)
          OP_LOAD, OP_STORE: w_next_state = S_MEMADR;
          OP_RTYPE:          w_next_state = S_EXEC_R;
          OP_ITYPE:          w_next_state = S_EXEC_I;
          OP_BRANCH:         w_next_state = S_BRANCH;
          OP_JAL:            w_next_state = S_JAL;
          OP_JALR:           w_next_state = S_JALR;
          OP_LUI:            w_next_state = S_LUI;
          OP_AUIPC:          w_next_state = S_AUIPC;
          default: begin
            w_ctrl.illegal_instr = 1'b1;
            w_next_state         = S_FETCH;
          end
        endcase
      end
      S_MEMADR: begin
        w_ctrl.alu_src_a = SRCA_RS1;
        w_ctrl.alu_src_b = SRCB_IMM;
        w_ctrl.alu_op    = ALU_ADD;
        w_next_state     = (opcode == OP_LOAD) ? S_MEMREAD : S_MEMWRITE;
      end
      S_MEMREAD: begin
        w_ctrl.adr_src    = 1'b1;
        w_ctrl.result_src = RES_ALUOUT;
        w_next_state      = S_MEMWB;
      end
      S_MEMWB: begin
        w_ctrl.result_src = RES_MEMDATA;
        w_ctrl.reg_write  = 1'b1;
        w_next_state      = S_FETCH;
      end
      S_MEMWRITE: begin
        w_ctrl.adr_src    = 1'b1;
        w_ctrl.result_src = RES_ALUOUT;
        w_ctrl.mem_write  = 1'b1;
        w_next_state      = S_FETCH;
      end
      S_EXEC_R: begin
        w_ctrl.alu_src_a = SRCA_RS1;
        w_ctrl.alu_src_b = SRCB_RS2;
        w_ctrl.alu_op    = ALU_FUNC;
        w_next_state     = S_ALUWB;
      end
      S_EXEC_I: begin
        w_ctrl.alu_src_a = SRCA_RS1;
        w_ctrl.alu_src_b = SRCB_IMM;
        w_ctrl.alu_op    = ALU_FUNC;
        w_next_state     = S_ALUWB;
      end
      S_ALUWB: begin
        w_ctrl.result_src = RES_ALUOUT;
        w_ctrl.reg_write  = 1'b1;
        w_next_state      = S_FETCH;
      end
      S_BRANCH: begin
        w_ctrl.alu_src_a  = SRCA_RS1;
        w_ctrl.alu_src_b  = SRCB_RS2;
        w_ctrl.alu_op     = ALU_SUB;
        w_ctrl.result_src = RES_ALUOUT;
        w_ctrl.pc_write   = w_taken;
        w_next_state      = S_FETCH;
      end
      S_JAL: begin
        w_ctrl.alu_src_a  = SRCA_OLDPC;
        w_ctrl.alu_src_b  = SRCB_FOUR;
        w_ctrl.alu_op     = ALU_ADD;
        w_ctrl.result_src = RES_ALUOUT;
        w_ctrl.pc_write   = 1'b1;
        w_next_state      = S_ALUWB;
      end
      S_JALR: begin
        // first sub-step jumps to rs1+imm, second builds the old PC + 4 link
        if (!r_jalr_link) begin
          w_ctrl.alu_src_a  = SRCA_RS1;
          w_ctrl.alu_src_b  = SRCB_IMM;
          w_ctrl.alu_op     = ALU_ADD;
          w_ctrl.result_src = RES_ALURESULT;
          w_ctrl.pc_write   = 1'b1;
          w_next_jalr_link  = 1'b1;
          w_next_state      = S_JALR;
        end else begin
          w_ctrl.alu_src_a = SRCA_OLDPC;
          w_ctrl.alu_src_b = SRCB_FOUR;
          w_ctrl.alu_op    = ALU_ADD;
          w_next_state     = S_ALUWB;
        end
      end
      S_LUI: begin
        w_ctrl.result_src = RES_IMM;
        w_ctrl.reg_write  = 1'b1;
        w_next_state      = S_FETCH;
      end
      S_AUIPC: begin
        w_ctrl.alu_src_a = SRCA_OLDPC;
        w_ctrl.alu_src_b = SRCB_IMM;
        w_ctrl.alu_op    = ALU_ADD;
        w_next_state     = S_ALUWB;
      end
      default: w_next_state = S_FETCH;
    endcase
    if (rst) begin
      w_ctrl = CTRL_IDLE;
    end
  end

  assign pc_write      = w_ctrl.pc_write;
  assign adr_src       = w_ctrl.adr_src;
  assign mem_write     = w_ctrl.mem_write;
  assign ir_write      = w_ctrl.ir_write;
  assign result_src    = w_ctrl.result_src;
  assign alu_src_a     = w_ctrl.alu_src_a;
  assign alu_src_b     = w_ctrl.alu_src_b;
  assign alu_op        = w_ctrl.alu_op;
  assign reg_write     = w_ctrl.reg_write;
  assign illegal_instr = w_ctrl.illegal_instr;

endmodule
